// File: rtl/calc_sequencer.sv
// Calculator sequencer: keypad entry, operand staging, ALU capture and display.
// One explicit state machine owns all operand, result and display registers.
module calc_sequencer #(
    parameter int MAG_W = 8
) (
    input  logic             hwclk,
    input  logic             reset,
    input  logic             key_strobe,
    input  logic [4:0]       key_code,
    input  logic [MAG_W:0]   alu_result,
    input  logic             alu_oflag,
    output logic [MAG_W:0]   op1,
    output logic [MAG_W:0]   op2,
    output logic [2:0]       opcode,
    output logic [MAG_W-1:0] disp_value,
    output logic             disp_neg,
    output logic             err,
    output logic             result_ready,
    output logic [2:0]       state
);

    localparam int PW = MAG_W + 4;
    localparam logic [PW-1:0] MAXV = PW'((1 << MAG_W) - 1);

    typedef enum logic [2:0] {
        ENTRY_A = 3'd0,
        ENTRY_B = 3'd1,
        EXEC    = 3'd2,
        RESULT  = 3'd3,
        ERROR   = 3'd4
    } state_t;

    state_t cur, nxt;

    logic [MAG_W-1:0] emag, n_emag;
    logic             eneg, n_eneg;
    logic             hd, n_hd;
    logic [MAG_W:0]   res, n_res;
    logic [MAG_W:0]   n_op1, n_op2;
    logic [2:0]       n_opc;
    logic [MAG_W-1:0] n_dv;
    logic             n_dn, n_err, n_rr;

    logic             is_digit, is_op, is_enter, is_clear, is_sign;
    logic [PW-1:0]    acc;
    logic             acc_ok;
    logic [MAG_W-1:0] kdig;
    logic [2:0]       kop;

    assign is_digit = key_strobe && (key_code < 5'd10);
    assign is_op    = key_strobe && (key_code >= 5'd10)
                      && (key_code <= 5'd15);
    assign is_enter = key_strobe && (key_code == 5'd16);
    assign is_clear = key_strobe && (key_code == 5'd17);
    assign is_sign  = key_strobe && (key_code == 5'd18);

    assign kdig   = MAG_W'(key_code[3:0]);
    assign kop    = 3'(key_code - 5'd10);
    // Decimal shift-in checked in a wider accumulator before committing
    assign acc    = PW'(emag) * PW'(10) + PW'(key_code[3:0]);
    assign acc_ok = (acc <= MAXV);

    assign state = cur;

    always_comb begin
        nxt    = cur;
        n_emag = emag;
        n_eneg = eneg;
        n_hd   = hd;
        n_res  = res;
        n_op1  = op1;
        n_op2  = op2;
        n_opc  = opcode;
        n_dv   = disp_value;
        n_dn   = disp_neg;
        n_err  = err;
        n_rr   = 1'b0;

        unique case (cur)
            ENTRY_A, ENTRY_B: begin
                unique case (1'b1)
                    is_digit: begin
                        if (acc_ok) begin
                            n_emag = acc[MAG_W-1:0];
                            n_hd   = 1'b1;
                        end
                    end
                    is_sign: begin
                        if (emag != '0) n_eneg = ~eneg;
                    end
                    is_op: begin
                        if (cur == ENTRY_A) begin
                            n_opc  = kop;
                            n_emag = '0;
                            n_eneg = 1'b0;
                            n_hd   = 1'b0;
                            nxt    = ENTRY_B;
                        end else if (!hd) begin
                            n_opc = kop;
                        end
                    end
                    is_enter: begin
                        if (cur == ENTRY_B && hd) nxt = EXEC;
                    end
                    default: ;
                endcase
            end
            EXEC: begin
                n_res = alu_result;
                n_rr  = 1'b1;
                nxt   = alu_oflag ? ERROR : RESULT;
            end
            RESULT: begin
                unique case (1'b1)
                    is_digit: begin
                        n_emag = kdig;
                        n_eneg = 1'b0;
                        n_hd   = 1'b1;
                        n_op2  = '0;
                        nxt    = ENTRY_A;
                    end
                    is_op: begin
                        n_op1  = res;
                        n_opc  = kop;
                        n_emag = '0;
                        n_eneg = 1'b0;
                        n_hd   = 1'b0;
                        nxt    = ENTRY_B;
                    end
                    is_enter: begin
                        n_op1 = res;
                        nxt   = EXEC;
                    end
                    default: ;
                endcase
            end
            ERROR: ;
            default: nxt = ENTRY_A;
        endcase

        // Operand under construction always tracks the entry register
        if (nxt == ENTRY_A) n_op1 = {n_eneg, n_emag};
        if (nxt == ENTRY_B) n_op2 = {n_eneg, n_emag};

        unique case (nxt)
            ENTRY_A, ENTRY_B: begin
                n_dv  = n_emag;
                n_dn  = n_eneg;
                n_err = 1'b0;
            end
            RESULT: begin
                n_dv  = n_res[MAG_W-1:0];
                n_dn  = n_res[MAG_W];
                n_err = 1'b0;
            end
            ERROR: begin
                n_dv  = '0;
                n_dn  = 1'b0;
                n_err = 1'b1;
            end
            default: ;
        endcase

        if (is_clear && cur != EXEC) begin
            nxt    = ENTRY_A;
            n_emag = '0;
            n_eneg = 1'b0;
            n_hd   = 1'b0;
            n_res  = '0;
            n_op1  = '0;
            n_op2  = '0;
            n_opc  = '0;
            n_dv   = '0;
            n_dn   = 1'b0;
            n_err  = 1'b0;
            n_rr   = 1'b0;
        end
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            cur          <= ENTRY_A;
            emag         <= '0;
            eneg         <= 1'b0;
            hd           <= 1'b0;
            res          <= '0;
            op1          <= '0;
            op2          <= '0;
            opcode       <= '0;
            disp_value   <= '0;
            disp_neg     <= 1'b0;
            err          <= 1'b0;
            result_ready <= 1'b0;
        end else begin
            cur          <= nxt;
            emag         <= n_emag;
            eneg         <= n_eneg;
            hd           <= n_hd;
            res          <= n_res;
            op1          <= n_op1;
            op2          <= n_op2;
            opcode       <= n_opc;
            disp_value   <= n_dv;
            disp_neg     <= n_dn;
            err          <= n_err;
            result_ready <= n_rr;
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed scenarios plus random keys
// against an integer-level calculator model and a simple ALU.
module tb_calc_sequencer;

    logic       hwclk = 1'b0;
    logic       reset;
    logic       key_strobe;
    logic [4:0] key_code;
    logic [8:0] alu_result;
    logic       alu_oflag;
    logic [8:0] op1, op2;
    logic [2:0] opcode;
    logic [7:0] disp_value;
    logic       disp_neg, err, result_ready;
    logic [2:0] state;

    int total = 0;
    int bad = 0;

    int m_st, m_op1, m_op2, m_opc, m_res, e_mag, m_dv;
    bit e_neg, e_hd, m_dn, m_err, m_rr;

    calc_sequencer #(.MAG_W(8)) dut (
        .hwclk(hwclk), .reset(reset),
        .key_strobe(key_strobe), .key_code(key_code),
        .alu_result(alu_result), .alu_oflag(alu_oflag),
        .op1(op1), .op2(op2), .opcode(opcode),
        .disp_value(disp_value), .disp_neg(disp_neg),
        .err(err), .result_ready(result_ready), .state(state)
    );

    always #5 hwclk = ~hwclk;

    function automatic int alu_val(int a, int b, int opc);
        case (opc)
            0: return a + b;
            1: return a - b;
            2: return a * b;
            3: return (b == 0) ? 0 : a / b;
            default: return a;
        endcase
    endfunction

    function automatic bit alu_ovf(int a, int b, int opc);
        int v;
        v = alu_val(a, b, opc);
        return (opc == 3 && b == 0) || v > 255 || v < -255;
    endfunction

    function automatic int sm2int(logic [8:0] x);
        return x[8] ? -int'(x[7:0]) : int'(x[7:0]);
    endfunction

    function automatic logic [8:0] int2sm(int v);
        logic [8:0] r;
        r[8]   = (v < 0);
        r[7:0] = (v < 0) ? 8'(-v) : 8'(v);
        return r;
    endfunction

    always_comb begin
        alu_result = int2sm(alu_val(sm2int(op1), sm2int(op2), int'(opcode)));
        alu_oflag  = alu_ovf(sm2int(op1), sm2int(op2), int'(opcode));
    end

    task automatic model_reset();
        m_st = 0; m_op1 = 0; m_op2 = 0; m_opc = 0; m_res = 0;
        e_mag = 0; e_neg = 0; e_hd = 0;
        m_dv = 0; m_dn = 0; m_err = 0; m_rr = 0;
    endtask

    function automatic int ent();
        return e_neg ? -e_mag : e_mag;
    endfunction

    task automatic model_step(input bit k, input int c, input bit r);
        bit d, o, en, cl, sg;
        m_rr = 0;
        d  = k && c < 10;
        o  = k && c >= 10 && c <= 15;
        en = k && c == 16;
        cl = k && c == 17;
        sg = k && c == 18;
        if (r || (cl && m_st != 2)) begin
            model_reset();
            return;
        end
        case (m_st)
            0, 1: begin
                if (d && e_mag * 10 + c <= 255) begin
                    e_mag = e_mag * 10 + c;
                    e_hd = 1;
                end
                if (sg && e_mag != 0) e_neg = !e_neg;
                if (o && m_st == 0) begin
                    m_opc = c - 10;
                    e_mag = 0; e_neg = 0; e_hd = 0;
                    m_st = 1;
                end else if (o && !e_hd) begin
                    m_opc = c - 10;
                end
                if (en && m_st == 1 && e_hd) m_st = 2;
                if (m_st == 0) m_op1 = ent();
                if (m_st == 1) m_op2 = ent();
            end
            2: begin
                m_res = alu_val(m_op1, m_op2, m_opc);
                m_rr = 1;
                m_st = alu_ovf(m_op1, m_op2, m_opc) ? 4 : 3;
            end
            3: begin
                if (d) begin
                    e_mag = c; e_neg = 0; e_hd = 1;
                    m_op1 = c; m_op2 = 0;
                    m_st = 0;
                end else if (o) begin
                    m_op1 = m_res; m_opc = c - 10;
                    e_mag = 0; e_neg = 0; e_hd = 0;
                    m_op2 = 0;
                    m_st = 1;
                end else if (en) begin
                    m_op1 = m_res;
                    m_st = 2;
                end
            end
            default: ;
        endcase
        case (m_st)
            0, 1: begin m_dv = e_mag; m_dn = e_neg; end
            3: begin
                m_dv = (m_res < 0) ? -m_res : m_res;
                m_dn = (m_res < 0);
            end
            4: begin m_dv = 0; m_dn = 0; end
            default: ;
        endcase
        m_err = (m_st == 4);
    endtask

    task automatic tick(input bit k, input int c, input bit r);
        @(negedge hwclk);
        key_strobe = k;
        key_code   = 5'(c);
        reset      = r;
        @(posedge hwclk);
        model_step(k, c, r);
        #1;
        key_strobe = 0;
        reset = 0;
    endtask

    task automatic test_reset();
        tick(0, 0, 1);
        tick(1, 5, 1);
        total++;
        if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
        total++;
        if (op1 !== 9'd0 || op2 !== 9'd0 || opcode !== 3'd0) begin
            bad++; $display("FAIL rst_ops got=%0h/%0h/%0d exp=0/0/0", op1, op2, opcode);
        end
        total++;
        if (disp_value !== 8'd0 || disp_neg !== 1'b0 || err !== 1'b0 || result_ready !== 1'b0) begin
            bad++; $display("FAIL rst_disp got=%0d/%b/%b/%b exp=0/0/0/0",
                            disp_value, disp_neg, err, result_ready);
        end
    endtask

    task automatic test_basic();
        int keys[7] = '{1, 2, 3, 10, 4, 5, 16};
        foreach (keys[i]) tick(1, keys[i], 0);
        total++;
        if (op1 !== 9'd123 || op2 !== 9'd45 || opcode !== 3'd0 || state !== 3'd2) begin
            bad++; $display("FAIL basic_ops got=%0d/%0d/%0d/st%0d exp=123/45/0/st2",
                            op1, op2, opcode, state);
        end
        tick(0, 0, 0);
        total++;
        if (disp_value !== 8'd168 || result_ready !== 1'b1 || state !== 3'd3) begin
            bad++; $display("FAIL basic_res got=%0d/%b/st%0d exp=168/1/st3",
                            disp_value, result_ready, state);
        end
        tick(0, 0, 0);
        total++;
        if (result_ready !== 1'b0) begin bad++; $display("FAIL basic_rr_pulse got=%b exp=0", result_ready); end
    endtask

    task automatic test_chain();
        tick(1, 11, 0);
        tick(1, 8, 0);
        tick(1, 16, 0);
        total++;
        if (op1 !== 9'd168 || op2 !== 9'd8 || opcode !== 3'd1) begin
            bad++; $display("FAIL chain_ops got=%0d/%0d/%0d exp=168/8/1", op1, op2, opcode);
        end
        tick(0, 0, 0);
        total++;
        if (disp_value !== 8'd160) begin bad++; $display("FAIL chain_res got=%0d exp=160", disp_value); end
        tick(1, 16, 0);
        total++;
        if (op1 !== 9'd160 || state !== 3'd2) begin
            bad++; $display("FAIL repeat_op1 got=%0d/st%0d exp=160/st2", op1, state);
        end
        tick(0, 0, 0);
        total++;
        if (disp_value !== 8'd152) begin bad++; $display("FAIL repeat_res got=%0d exp=152", disp_value); end
    endtask

    task automatic test_digit_limit();
        tick(1, 17, 0);
        tick(1, 2, 0);
        tick(1, 5, 0);
        tick(1, 6, 0);
        total++;
        if (disp_value !== 8'd25) begin bad++; $display("FAIL limit_drop got=%0d exp=25", disp_value); end
        tick(1, 5, 0);
        total++;
        if (disp_value !== 8'd255 || op1 !== 9'd255) begin
            bad++; $display("FAIL limit_max got=%0d/%0d exp=255/255", disp_value, op1);
        end
    endtask

    task automatic test_overflow();
        int keys[5] = '{3, 10, 16, 18, 7};
        tick(1, 10, 0);
        tick(1, 1, 0);
        tick(1, 16, 0);
        tick(0, 0, 0);
        total++;
        if (state !== 3'd4 || err !== 1'b1 || disp_value !== 8'd0) begin
            bad++; $display("FAIL ovf_err got=st%0d/%b/%0d exp=st4/1/0", state, err, disp_value);
        end
        foreach (keys[i]) tick(1, keys[i], 0);
        total++;
        if (state !== 3'd4 || err !== 1'b1 || disp_value !== 8'd0) begin
            bad++; $display("FAIL ovf_ignore got=st%0d/%b/%0d exp=st4/1/0", state, err, disp_value);
        end
        tick(1, 17, 0);
        total++;
        if (state !== 3'd0 || err !== 1'b0) begin
            bad++; $display("FAIL ovf_clear got=st%0d/%b exp=st0/0", state, err);
        end
    endtask

    task automatic test_sign();
        tick(1, 18, 0);
        total++;
        if (disp_neg !== 1'b0) begin bad++; $display("FAIL sign_empty got=%b exp=0", disp_neg); end
        tick(1, 7, 0);
        tick(1, 18, 0);
        total++;
        if (disp_neg !== 1'b1 || op1 !== 9'h107) begin
            bad++; $display("FAIL sign_neg got=%b/%0h exp=1/107", disp_neg, op1);
        end
        tick(1, 10, 0);
        tick(1, 12, 0);
        total++;
        if (opcode !== 3'd2 || state !== 3'd1) begin
            bad++; $display("FAIL op_replace got=%0d/st%0d exp=2/st1", opcode, state);
        end
    endtask

    task automatic test_reset_mid();
        tick(1, 3, 1);
        total++;
        if (state !== 3'd0 || op1 !== 9'd0 || op2 !== 9'd0 || opcode !== 3'd0
            || disp_value !== 8'd0 || disp_neg !== 1'b0) begin
            bad++; $display("FAIL rst_mid got=st%0d/%0h/%0h/%0d/%0d/%b exp=st0/0/0/0/0/0",
                            state, op1, op2, opcode, disp_value, disp_neg);
        end
    endtask

    task automatic test_exec_drop();
        int keys[4] = '{5, 10, 3, 16};
        foreach (keys[i]) tick(1, keys[i], 0);
        tick(1, 17, 0);
        total++;
        if (state !== 3'd3 || disp_value !== 8'd8 || result_ready !== 1'b1) begin
            bad++; $display("FAIL exec_drop got=st%0d/%0d/%b exp=st3/8/1",
                            state, disp_value, result_ready);
        end
    endtask

    task automatic test_random();
        int r, c;
        bit k, rs;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            k = 1;
            if (r < 45) c = $urandom_range(0, 9);
            else if (r < 60) c = $urandom_range(10, 15);
            else if (r < 70) c = 16;
            else if (r < 74) c = 17;
            else if (r < 80) c = 18;
            else if (r < 86) c = $urandom_range(19, 31);
            else begin k = 0; c = 0; end
            rs = ($urandom_range(0, 99) == 0);
            tick(k, c, rs);
            total++;
            if (state !== 3'(m_st) || op1 !== int2sm(m_op1) || opcode !== 3'(m_opc)) begin
                bad++; $display("FAIL rnd_core n=%0d got=st%0d/%0h/%0d exp=st%0d/%0h/%0d",
                                n, state, op1, opcode, m_st, int2sm(m_op1), m_opc);
            end
            if (!(m_st == 1 && !e_hd)) begin
                total++;
                if (op2 !== int2sm(m_op2)) begin
                    bad++; $display("FAIL rnd_op2 n=%0d got=%0h exp=%0h", n, op2, int2sm(m_op2));
                end
            end
            total++;
            if (disp_value !== 8'(m_dv) || disp_neg !== m_dn || err !== m_err
                || result_ready !== m_rr) begin
                bad++; $display("FAIL rnd_disp n=%0d got=%0d/%b/%b/%b exp=%0d/%b/%b/%b",
                                n, disp_value, disp_neg, err, result_ready,
                                m_dv, m_dn, m_err, m_rr);
            end
        end
    endtask

    initial begin
        reset = 1;
        key_strobe = 0;
        key_code = 0;
        model_reset();
        test_reset();
        test_basic();
        test_chain();
        test_digit_limit();
        test_overflow();
        test_sign();
        test_reset_mid();
        test_exec_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
